// File: rtl/pwm_capture.sv
// pwm_capture: measures a PWM waveform in clock cycles. Once per input period it
// reports the high time and the period (cycles between consecutive rising edges).
// Optional stuck-input detection: define PWM_CAPTURE_TIMEOUT_EN to emit a timeout
// report whenever no rising edge is seen for TIMEOUT_CYC cycles. Without the macro
// stuck_o/stuck_level_o are tied low and a static input just saturates the counts.
module pwm_capture #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic             pwm_in_i,
  output logic [CNT_W-1:0] high_cnt_o,
  output logic [CNT_W-1:0] period_cnt_o,
  output logic             meas_valid_o,
  output logic             ovf_o,
  output logic             stuck_o,
  output logic             stuck_level_o
);

  typedef enum logic [0:0] {
    StIdle,
    StMeas
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Synchronizer chain and edge detect
  logic s1_q, s2_q, s3_q;
  logic rise;

  // Measurement state
  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_acc_q, per_acc_d;
  logic [CNT_W-1:0] hi_acc_q, hi_acc_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic             per_at_max;
  logic             hi_at_max;

  // Registered results
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             ovf_q, ovf_d;

  // Two-flop synchronizer plus a delay flop for edge detection; runs regardless of ena_i
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise       = s2_q & ~s3_q;
  assign per_at_max = (per_acc_q == CntMax);
  assign hi_at_max  = (hi_acc_q == CntMax);

`ifdef PWM_CAPTURE_TIMEOUT_EN
  // Counter value in the cycle that fires a timeout; it reads TIMEOUT_CYC-1 there, so
  // the report lands TIMEOUT_CYC edges after the last rise or entry to idle.
  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit;
  logic             stuck_q, stuck_d;
  logic             stuck_level_q, stuck_level_d;

  assign tmo_hit = (tmo_cnt_q == TmoLast);

  // Cycles since the last rise (or idle entry); cleared by rise, timeout or disable
  always_comb begin
    tmo_cnt_d = tmo_cnt_q + CntOne;
    if (!ena_i || rise || tmo_hit) begin
      tmo_cnt_d = '0;
    end
  end

  // Timeout counter and stuck result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign stuck_o       = stuck_q;
  assign stuck_level_o = stuck_level_q;
`else
  // Timeout length only matters when the timeout logic is built
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;

  assign stuck_o       = 1'b0;
  assign stuck_level_o = 1'b0;
`endif

  // Next-state, accumulator and report logic; ena_i low overrides everything
  always_comb begin
    state_d      = state_q;
    per_acc_d    = per_acc_q;
    hi_acc_d     = hi_acc_q;
    ovf_acc_d    = ovf_acc_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    ovf_d        = ovf_q;
    meas_valid_d = 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;
`endif

    if (!ena_i) begin
      // Abandon the current period; results hold their last values
      state_d   = StIdle;
      per_acc_d = '0;
      hi_acc_d  = '0;
      ovf_acc_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rise) begin
            // First edge only opens a period, nothing to report yet
            state_d   = StMeas;
            per_acc_d = CntOne;
            hi_acc_d  = CntOne;
            ovf_acc_d = 1'b0;
          end
`ifdef PWM_CAPTURE_TIMEOUT_EN
          else if (tmo_hit) begin
            high_cnt_d    = {CNT_W{s2_q}};
            period_cnt_d  = CntMax;
            ovf_d         = 1'b0;
            stuck_d       = 1'b1;
            stuck_level_d = s2_q;
            meas_valid_d  = 1'b1;
          end
`endif
        end

        StMeas: begin
          if (rise) begin
            // Close the period and start the next one on this rising edge
            period_cnt_d = per_acc_q;
            high_cnt_d   = hi_acc_q;
            ovf_d        = ovf_acc_q;
            meas_valid_d = 1'b1;
`ifdef PWM_CAPTURE_TIMEOUT_EN
            stuck_d      = 1'b0;
`endif
            per_acc_d    = CntOne;
            hi_acc_d     = CntOne;
            ovf_acc_d    = 1'b0;
          end
`ifdef PWM_CAPTURE_TIMEOUT_EN
          else if (tmo_hit) begin
            high_cnt_d    = {CNT_W{s2_q}};
            period_cnt_d  = CntMax;
            ovf_d         = 1'b0;
            stuck_d       = 1'b1;
            stuck_level_d = s2_q;
            meas_valid_d  = 1'b1;
            state_d       = StIdle;
            per_acc_d     = '0;
            hi_acc_d      = '0;
            ovf_acc_d     = 1'b0;
          end
`endif
          else begin
            // Saturating accumulation; ovf remembers that the period ran past max
            if (!per_at_max) begin
              per_acc_d = per_acc_q + CntOne;
            end
            if (s2_q && !hi_at_max) begin
              hi_acc_d = hi_acc_q + CntOne;
            end
            ovf_acc_d = ovf_acc_q | per_at_max;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State, accumulator and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      per_acc_q    <= '0;
      hi_acc_q     <= '0;
      ovf_acc_q    <= 1'b0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      meas_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_acc_q    <= per_acc_d;
      hi_acc_q     <= hi_acc_d;
      ovf_acc_q    <= ovf_acc_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      meas_valid_q <= meas_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign high_cnt_o   = high_cnt_q;
  assign period_cnt_o = period_cnt_q;
  assign meas_valid_o = meas_valid_q;
  assign ovf_o        = ovf_q;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the PWM waveform produced by the duty-cycle generator, reporting high time and period in clock cycles once per PWM period. Sits directly downstream of the generator's `uo_out[0]` and gives a self-check and readback path for the duty setting. It also flags a stuck output at duty 0 or 100 %.

## Interface
- `CNT_W`, default 8: width of the cycle accumulators and result registers.
- `TIMEOUT_CYC`, default 200: cycles without a rising edge before the input is declared stuck. Must be ≤ 2^CNT_W−1.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: measurement enable, synchronous.
- `pwm_in` in 1: PWM under measurement, asynchronous to `clk`.
- `high_cnt` out CNT_W: cycles `pwm_in` was high in the last completed period.
- `period_cnt` out CNT_W: cycles between the last two rising edges.
- `meas_valid` out 1: one-cycle pulse when `high_cnt`/`period_cnt`/`ovf`/`stuck` update.
- `ovf` out 1: the last reported period saturated the accumulator.
- `stuck` out 1: the last report was a timeout; only functional with the timeout macro.
- `stuck_level` out 1: synchronized `pwm_in` level at timeout.

## Operation
- **Synchronizer:** `pwm_in` passes through a 2-FF synchronizer (`s1`→`s2`) plus a delay FF `s3`.
- **Edge detect:** rise = `s2 & ~s3`.
- **FSM states:**
  - IDLE: waiting for the first rising edge.
  - MEAS: accumulating.
- **Reset:**
  - State = IDLE; `s1`/`s2`/`s3` = 0; accumulators = 0.
  - All outputs = 0.
- **IDLE → MEAS** on rise. Set `per_acc`=1 and `hi_acc`=1; no report.
- **MEAS, rise:**
  - Report: `period_cnt`←`per_acc`, `high_cnt`←`hi_acc`, `ovf`←`ovf_acc`, `stuck`←0, `meas_valid`←1.
  - Then `per_acc`←1, `hi_acc`←1, `ovf_acc`←0.
- **MEAS, no rise:**
  - `per_acc` increments, saturating at 2^CNT_W−1.
  - `hi_acc` increments when `s2`=1, with the same saturation.
  - `ovf_acc`←1 if `per_acc` is already at max.
- **`ena`=0:**
  - Synchronous return to IDLE; accumulators cleared; no `meas_valid`.
  - Result outputs hold their last values.
  - The synchronizer keeps running.
- **Outputs:** all registered; they change only in the `meas_valid` cycle.
- **Mid-measurement reset:** the partial period is discarded, outputs go to 0, and the next report requires two rising edges after `rst_n` deasserts.

## Timing
- **Report latency:**
  - Edge N is the first clock edge at which `pwm_in` is sampled high.
  - `s2`=1 after N+1.
  - The report registers and `meas_valid` are high for exactly the cycle following edge N+2.
- **Report rate:** `meas_valid` pulses once per input period. The minimum measurable period is 2 cycles (high 1, low 1).
- **Pulse width:** `meas_valid` is never high two consecutive cycles unless consecutive rises are 1 cycle apart, which is impossible for a 1-bit input.
- **Simultaneous `ena` fall and rise:** `ena`=0 wins; no report.
- **Simultaneous timeout and rise:** the rise wins. A normal report is issued with `period_cnt`=TIMEOUT_CYC.

## Configuration
- **Macro:** `PWM_CAPTURE_TIMEOUT_EN`.
- **Defined — timeout behaviour:** in IDLE or MEAS, a counter of cycles since the last rise (or since entering IDLE) that reaches TIMEOUT_CYC triggers a timeout report:
  - `stuck`←1, `stuck_level`←`s2`;
  - `high_cnt`←`s2` ? all-ones : 0;
  - `period_cnt`←all-ones, `ovf`←0, `meas_valid`←1.
- **After a timeout:**
  - State → IDLE, counter cleared.
  - The timeout repeats every TIMEOUT_CYC cycles while the input stays static.
- **Not defined:**
  - No timeout logic; `stuck` and `stuck_level` are tied 0.
  - A static input produces no reports; the accumulators simply saturate.

## Test plan
- **Normal duty:** generator period 10, duty 5 → every `meas_valid` shows `period_cnt`=10, `high_cnt`=5, `ovf`=0, spaced 10 cycles apart; first report 2 cycles after the second sampled rise.
- **Duty step:** duty 5→9 mid-stream → one report shows a transitional value, then steady `high_cnt`=9, `period_cnt`=10.
- **Stuck input (macro on):** `pwm_in` held 0 after reset → `meas_valid` at cycle 200 with `stuck`=1, `stuck_level`=0, `high_cnt`=0, `period_cnt`=255; repeats at 400. Held 1 → `high_cnt`=255, `stuck_level`=1.
- **Overflow (macro off):** `CNT_W`=8, period 300, high 100 → `period_cnt`=255, `high_cnt`=100, `ovf`=1.
- **Enable drop:** `ena` dropped for 3 cycles mid-period → no `meas_valid` for that period; outputs hold; the next valid report comes after two further rises.
- **Async reset:** `rst_n` pulsed low between clock edges mid-period → all outputs 0 immediately, no report until two rises after release.
